pe_lport: RTL

PE_LPORT -- requirements
Module: pe_lport

---
 rtl/pe_lport_pkg.sv | 31 +++
 rtl/pe_lport_fifo.sv | 67 ++++++
 rtl/pe_lport.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pe_lport_pkg.sv
// Shared types and sizes for the local (PE-side) router port.
// The project-wide widths normally arrive from define.v; the guarded
// fallbacks below only take effect when that file has not been read first.
`ifndef DATAW
`define DATAW 15
`endif
`ifndef VCH
`define VCH 1
`endif
`ifndef VCHW
`define VCHW 0
`endif

package pe_lport_pkg;

    localparam int DATA_W = `DATAW + 1;
    localparam int NUM_VC = `VCH + 1;
    localparam int VC_W   = `VCHW + 1;

    typedef logic [DATA_W-1:0] flit_t;
    typedef logic [VC_W-1:0]   vc_t;

    // The round-robin pointer starts on the last VC so VC0 wins first.
    localparam vc_t RR_RESET = vc_t'(`VCH);

    // Maps an offset from the round-robin pointer onto a real VC number.
    function automatic vc_t vc_wrap(input int idx);
        return vc_t'(idx % NUM_VC);
    endfunction

endpackage

// File: rtl/pe_lport_fifo.sv
// Single-VC synchronous injection FIFO. Exposes the head flit, the current
// occupancy and the occupancy it will have after this clock edge.
module lport_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   next_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             take;
    logic             accept;

    // A full FIFO still accepts a write when its head leaves in the same cycle.
    assign full   = (count == CNT_W'(DEPTH));
    assign take   = pop && (count != '0);
    assign accept = push && (!full || take);
    assign head   = mem[rd_ptr];

    // Occupancy after this edge; also feeds the registered ready upstream.
    always_comb begin
        next_count = count;
        if (accept && !take) begin
            next_count = count + CNT_W'(1);
        end else if (!accept && take) begin
            next_count = count - CNT_W'(1);
        end
    end

    // Flit storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (take) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= next_count;
        end
    end

endmodule

// File: rtl/pe_lport.sv
// Local port between a processing element and its router: per-VC injection
// FIFOs with round-robin, per-flit arbitration toward the switch, and a
// one-stage registered ejection path back to the PE.
module pe_lport
    import pe_lport_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [`DATAW:0]   pe_odata,
    input  logic              pe_ovalid,
    input  logic [`VCHW:0]    pe_ovch,
    output logic [`VCH:0]     pe_irdy,
    output logic [`DATAW:0]   pe_idata,
    output logic              pe_ivalid,
    output logic [`DATAW:0]   sw_odata,
    output logic              sw_ovalid,
    output logic [`VCHW:0]    sw_ovch,
    input  logic [`VCH:0]     sw_ordy,
    input  logic [`DATAW:0]   sw_idata,
    input  logic              sw_ivalid,
    output logic              ovf_err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    flit_t             heads      [NUM_VC];
    logic [CNT_W-1:0]  count      [NUM_VC];
    logic [CNT_W-1:0]  next_count [NUM_VC];
    logic [NUM_VC-1:0] push;
    logic [NUM_VC-1:0] pop;
    logic [NUM_VC-1:0] eligible;
    logic [NUM_VC-1:0] overflow;
    logic [NUM_VC-1:0] irdy_next;
    vc_t               rr;
    vc_t               grant_vc;
    logic              grant;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign push[v]      = pe_ovalid && !rst_ && (pe_ovch == vc_t'(v));
        assign pop[v]       = grant && (grant_vc == vc_t'(v));
        assign eligible[v]  = (count[v] != '0) && sw_ordy[v];
        assign overflow[v]  = push[v] && (int'(count[v]) == DEPTH) && !pop[v];
        assign irdy_next[v] = (int'(next_count[v]) <= DEPTH - 2);

        lport_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (DATA_W)
        ) u_fifo (
            .clk        (clk),
            .rst_       (rst_),
            .push       (push[v]),
            .push_data  (pe_odata),
            .pop        (pop[v]),
            .head       (heads[v]),
            .count      (count[v]),
            .next_count (next_count[v])
        );
    end

    // Round-robin search starting one past the last granted VC.
    always_comb begin
        grant    = 1'b0;
        grant_vc = rr;
        for (int i = 1; i <= NUM_VC; i++) begin
            if (!grant && eligible[vc_wrap(int'(rr) + i)]) begin
                grant    = 1'b1;
                grant_vc = vc_wrap(int'(rr) + i);
            end
        end
    end

    // Registered switch output; data and VC hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst_) begin
            rr        <= RR_RESET;
            sw_ovalid <= 1'b0;
            sw_odata  <= '0;
            sw_ovch   <= '0;
        end else begin
            sw_ovalid <= grant;
            if (grant) begin
                rr       <= grant_vc;
                sw_odata <= heads[grant_vc];
                sw_ovch  <= grant_vc;
            end
        end
    end

    // Ready leaves one slot of headroom for a flit already on its way.
    always_ff @(posedge clk) begin
        if (rst_) begin
            pe_irdy <= '1;
        end else begin
            pe_irdy <= irdy_next;
        end
    end

    // Overflow is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst_) begin
            ovf_err <= 1'b0;
        end else if (|overflow) begin
            ovf_err <= 1'b1;
        end
    end

    // Ejection is a plain register stage; the PE always accepts.
    always_ff @(posedge clk) begin
        if (rst_) begin
            pe_ivalid <= 1'b0;
            pe_idata  <= '0;
        end else begin
            pe_ivalid <= sw_ivalid;
            pe_idata  <= sw_idata;
        end
    end

endmodule
